cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the Common Data Bus (CDB) among functional-unit result ports: add/sub unit, mul/div unit, and load unit.
- Sits between the functional units (enabled by the decoder's Add_en/Multiply_en/Load_en paths) and the reservation stations and register-status table, which snoop the CDB.
- Grants at most one result per cycle and broadcasts {tag, data} from a registered output.
- Round-robin fairness, with a starvation override.

Parameters:
- NUM_REQ, 3, number of result requesters (index 0 = add, 1 = mul/div, 2 = load).
- TAG_W, 4, reservation-station tag width; tag 0 means "no producer" and is illegal on the CDB.
- DATA_W, 32, result width.
- MAX_WAIT, 7, consecutive stalled cycles before a requester is forced to win; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash (branch mispredict); blocks grants and kills the pending broadcast.
- req_valid  in  NUM_REQ  per-requester result valid.
- req_tag  in  NUM_REQ*TAG_W  packed tags; requester i occupies bits [i*TAG_W +: TAG_W].
- req_data  in  NUM_REQ*DATA_W  packed results, same packing as req_tag.
- req_ready  out  NUM_REQ  one-hot-or-zero grant, combinational.
- cdb_valid  out  1  broadcast valid, registered.
- cdb_tag  out  TAG_W  broadcast tag, registered.
- cdb_data  out  DATA_W  broadcast data, registered.
- cdb_src  out  $clog2(NUM_REQ)  index of the winning requester, registered.
- err_zero_tag  out  1  sticky flag: a tag-0 request was accepted.

Behaviour:
- Reset (rst_n=0, async): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, err_zero_tag=0, rr_ptr=0, all wait counters=0. req_ready is combinational and is 0 while in reset.
- Handshake:
  - Transfer happens when req_valid[i] & req_ready[i] in the same cycle.
  - A requester holds valid/tag/data stable until it is granted.
  - Dropping valid before grant is legal and clears that requester's wait counter.
- Grant selection (combinational, every cycle flush=0):
  1. Starving set = requesters with valid=1 and wait_cnt ≥ MAX_WAIT. If non-empty, the lowest index in it wins.
  2. Otherwise, round-robin: search for the first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  3. No valid requester gives req_ready=0.
- Latency: the result accepted in cycle N appears on the CDB in cycle N+1 with cdb_valid=1 for exactly one cycle. Back-to-back grants give continuous cdb_valid.
- rr_ptr: on a grant to index g, rr_ptr ← (g+1) mod NUM_REQ. With no grant, rr_ptr is unchanged. A starvation grant also updates rr_ptr.
- Wait counter i:
  - Cleared on grant to i or when req_valid[i]=0.
  - Otherwise increments.
  - Saturates at MAX_WAIT.
- Tag 0:
  - A request with tag 0 is still granted normally (consumes its slot, advances rr_ptr).
  - Its broadcast is suppressed: cdb_valid=0 next cycle.
  - err_zero_tag sets and stays set until reset.
- flush=1:
  - req_ready=0 for all requesters.
  - Next cycle cdb_valid=0. A broadcast registered in the flush cycle's previous edge is unaffected.
  - rr_ptr and wait counters are held.
  - Functional units drop their own valids after a flush.
- cdb_tag, cdb_data and cdb_src hold their last values when cdb_valid=0.
- Simultaneous requests from all units: exactly one grant per cycle. Worst-case wait is NUM_REQ-1 cycles under round-robin alone.

Optional Feature:
- Macro: CDB_RR_EN.
- Defined: round-robin selection as above.
- Undefined:
  - Fixed priority, lowest index wins: add > mul/div > load.
  - rr_ptr logic is removed.
  - The starvation override remains, so load still gets a grant within MAX_WAIT+1 cycles.

Test Plan:
1. Reset mid-broadcast: grant tag 5 → pull rst_n low in the next cycle → cdb_valid=0 and req_ready=0 immediately; after release, first grant follows rr_ptr=0.
2. Single requester: cycle 0, valid[1]=1, tag=3, data=0x0000_0042 → ready[1]=1 in cycle 0; cycle 1: cdb_valid=1, tag=3, data=0x42, src=1; cycle 2: cdb_valid=0.
3. All three valid and held continuously (CDB_RR_EN defined) → grant order 0,1,2,0,… with cdb_src following it one cycle later and cdb_valid continuously 1.
4. Fixed priority (CDB_RR_EN undefined), MAX_WAIT=2:
   - Requesters 0 and 2 assert valid and keep re-asserting; requester 0 presents a new tag each cycle after every grant.
   - Load (requester 2) has wait_cnt=2 by the 3rd cycle and wins that cycle.
5. flush asserted for one cycle with all three valid → no req_ready that cycle, cdb_valid=0 the next cycle, and rr_ptr unchanged afterwards.
6. valid[0]=1 with tag=0 → ready[0]=1, cdb_valid stays 0 the next cycle, err_zero_tag=1 and stays 1 through later normal traffic.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Common Data Bus arbiter; define CDB_RR_EN for round-robin, otherwise fixed priority with starvation override
module cdb_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         cdb_valid,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [DATA_W-1:0]            cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]   cdb_src,
    output logic                         err_zero_tag
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // MAX_WAIT is limited to 255, so an 8-bit saturating counter always suffices
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]  wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] starving;
    logic              grant_any;
    logic [IDX_W-1:0]  grant_idx;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;

`ifdef CDB_RR_EN
    logic [IDX_W-1:0]  rr_ptr;
`endif

    // Requesters that have waited long enough to override the normal policy
    always_comb begin
        starving = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starving[i] = req_valid[i] && (wait_cnt[i] >= MAX_WAIT_C);
        end
    end

    // Winner selection: starvation first (lowest index), then the normal policy
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (|starving) begin
            grant_any = 1'b1;
            // Descending scan so the lowest starving index is the last assignment
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (starving[i]) begin
                    grant_idx = IDX_W'(i);
                end
            end
        end else begin
            grant_any = |req_valid;
`ifdef CDB_RR_EN
            // Descending distance from rr_ptr so the nearest valid requester wins
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                    grant_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                end
            end
`else
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    grant_idx = IDX_W'(i);
                end
            end
`endif
        end
        // A mispredict squash or reset blocks every grant
        if (flush || !rst_n) begin
            grant_any = 1'b0;
        end
    end

    // One-hot grant vector and the winner's tag/data
    always_comb begin
        req_ready = '0;
        sel_tag   = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_any && (grant_idx == IDX_W'(i));
            if (grant_idx == IDX_W'(i)) begin
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Registered broadcast; tag 0 consumes the slot but is never put on the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            cdb_src      <= '0;
            err_zero_tag <= 1'b0;
        end else begin
            cdb_valid <= 1'b0;
            if (grant_any) begin
                if (sel_tag == '0) begin
                    err_zero_tag <= 1'b1;
                end else begin
                    cdb_valid <= 1'b1;
                    cdb_tag   <= sel_tag;
                    cdb_data  <= sel_data;
                    cdb_src   <= grant_idx;
                end
            end
        end
    end

    // Per-requester stall counters; frozen during a flush so fairness state survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else if (!flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || req_ready[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] < MAX_WAIT_C) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef CDB_RR_EN
    // Round-robin pointer moves just past every winner, including starvation winners
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter with a rule-level reference model
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam int MW = 2;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [N-1:0]  req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic [SW-1:0] cdb_src;
    logic          err_zero_tag;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_src(cdb_src), .err_zero_tag(err_zero_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int            cyc;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            src;
    } exp_t;
    exp_t q[$];

    // Requester agents and reference-model state
    bit            v [N];
    logic [TW-1:0] t [N];
    logic [DW-1:0] d [N];
    int            wcnt [N];
    int            rr;
    bit            err_exp;
    int            last_grant;
    bit            last_flush;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v[i];
            req_tag[i*TW +: TW]   = t[i];
            req_data[i*DW +: DW]  = d[i];
        end
    endtask

    task automatic new_txn(input int i);
        v[i] = 1'b1;
        t[i] = TW'($urandom_range(1, 15));
        d[i] = $urandom;
    endtask

    task automatic drop_all();
        for (int i = 0; i < N; i++) v[i] = 1'b0;
    endtask

    task automatic renew_granted();
        if (last_grant >= 0) new_txn(last_grant);
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        rr = 0;
        err_exp = 1'b0;
        last_grant = -1;
        last_flush = 1'b0;
        q.delete();
    endtask

    // Who should win this cycle, from the arbitration rules
    function automatic int model_grant(bit fl);
        if (fl || !rst_n) return -1;
        for (int i = 0; i < N; i++)
            if (v[i] && wcnt[i] >= MW) return i;
`ifdef CDB_RR_EN
        for (int k = 0; k < N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
`else
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
`endif
        return -1;
    endfunction

    // Apply one cycle of stimulus, check the grant, queue the expected broadcast
    task automatic step(input bit fl);
        int   g;
        exp_t e;
        flush = fl;
        drive();
        #1;
        g = model_grant(fl);
        check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        check("err_zero_tag", err_zero_tag, err_exp);
        if (g >= 0) begin
            if (t[g] == '0) begin
                err_exp = 1'b1;
            end else begin
                e.cyc  = cyc + 1;
                e.tag  = t[g];
                e.data = d[g];
                e.src  = g;
                q.push_back(e);
            end
            rr = (g + 1) % N;
        end
        if (!fl) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] || i == g) wcnt[i] = 0;
                else if (wcnt[i] < MW) wcnt[i] = wcnt[i] + 1;
            end
        end
        last_grant = g;
    endtask

    task automatic agents();
        for (int i = 0; i < N; i++) begin
            if (v[i] && last_grant == i) begin
                if ($urandom_range(0, 99) < 70) new_txn(i);
                else v[i] = 1'b0;
            end else if (v[i]) begin
                if ($urandom_range(0, 19) == 0) v[i] = 1'b0;
            end else if ($urandom_range(0, 99) < 50) begin
                new_txn(i);
            end
        end
    endtask

    task automatic random_phase(input int n);
        bit fl;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            fl = ($urandom_range(0, 24) == 0);
            if (last_flush) drop_all();
            else agents();
            step(fl);
            last_flush = fl;
        end
    endtask

    // Monitor: every cycle the bus either carries the next queued result or is idle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            check("cdb_valid", cdb_valid, 1);
            check("cdb_tag", cdb_tag, e.tag);
            check("cdb_data", cdb_data, e.data);
            check("cdb_src", cdb_src, e.src);
        end else begin
            check("cdb_idle", cdb_valid, 0);
        end
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < N; i++) new_txn(i);
        drive();
        reset_model();
        #1;
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_cdb_tag", cdb_tag, 0);
        check("rst_cdb_data", cdb_data, 0);
        check("rst_cdb_src", cdb_src, 0);
        check("rst_err", err_zero_tag, 0);
        check("rst_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        drop_all();
        drive();
        #2 rst_n = 1'b1;

`ifdef CDB_RR_EN
        // All three held continuously: rotation 0,1,2,0
        for (int i = 0; i < N; i++) new_txn(i);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c > 0) renew_granted();
            step(1'b0);
            if (c < 4) check("rr_order", req_ready, (c == 3) ? 64'd1 : (64'd1 << c));
        end
`else
        // Add and load contend; load is forced through once it has stalled MAX_WAIT cycles
        new_txn(0);
        new_txn(2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) renew_granted();
            step(1'b0);
            check("fixed_prio", req_ready, (c == 2) ? 64'd4 : 64'd1);
        end
`endif
        @(negedge clk); drop_all(); step(1'b0);

        // Single requester latency
        @(negedge clk);
        v[1] = 1'b1; t[1] = 4'd3; d[1] = 32'h0000_0042;
        step(1'b0);
        check("single_ready", req_ready, 3'b010);
        @(negedge clk); v[1] = 1'b0; step(1'b0);
        check("single_valid", cdb_valid, 1);
        check("single_tag", cdb_tag, 3);
        check("single_data", cdb_data, 32'h42);
        check("single_src", cdb_src, 1);
        @(negedge clk); step(1'b0);
        check("single_gap", cdb_valid, 0);

        // Flush with all valid: no grant, previous broadcast survives, next cycle idle
        @(negedge clk); for (int i = 0; i < N; i++) new_txn(i); step(1'b0);
        @(negedge clk); renew_granted(); step(1'b1);
        check("flush_ready", req_ready, 0);
        @(negedge clk); drop_all(); step(1'b0);
        check("flush_kill", cdb_valid, 0);
        @(negedge clk); for (int i = 0; i < N; i++) new_txn(i); step(1'b0);
        @(negedge clk); drop_all(); step(1'b0);

        random_phase(300);
        @(negedge clk); drop_all(); step(1'b0);

        // Tag 0: granted, suppressed, sticky error
        @(negedge clk);
        v[0] = 1'b1; t[0] = '0; d[0] = $urandom;
        step(1'b0);
        check("zero_tag_ready", req_ready, 3'b001);
        @(negedge clk); drop_all(); step(1'b0);
        check("zero_tag_suppress", cdb_valid, 0);
        check("zero_tag_err", err_zero_tag, 1);

        random_phase(300);
        @(negedge clk); drop_all(); step(1'b0);
        check("zero_tag_sticky", err_zero_tag, 1);

        // Reset in the cycle a tag-5 broadcast is on the bus
        @(negedge clk);
        v[0] = 1'b1; t[0] = 4'd5; d[0] = 32'hCAFE_0005;
        step(1'b0);
        check("pre_reset_ready", req_ready, 3'b001);
        @(negedge clk);
        for (int i = 0; i < N; i++) new_txn(i);
        drive();
        #2 rst_n = 1'b0;
        #1;
        check("reset_kill_valid", cdb_valid, 0);
        check("reset_ready", req_ready, 0);
        check("reset_err", err_zero_tag, 0);
        reset_model();
        repeat (2) @(negedge clk);
        drop_all();
        drive();
        #2 rst_n = 1'b1;
        @(negedge clk); for (int i = 0; i < N; i++) new_txn(i); step(1'b0);
        check("post_reset_first", req_ready, 3'b001);
        @(negedge clk); drop_all(); step(1'b0);
        @(negedge clk); step(1'b0);
        @(negedge clk); #1;
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
